// File: rtl/sprite_evaluator.sv
// Per-scanline sprite evaluation: clears secondary OAM, scans primary OAM, copies up to 8 in-range sprites.
// Optional SPRITE_OVERFLOW_BUG_EN reproduces the original hardware's diagonal overflow scan.
module sprite_evaluator #(
  parameter int OAM_SPRITES = 64,
  parameter int SEC_SLOTS   = 8,
  parameter int CLEAR_DOTS  = 64
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       clock_EN,
  input  logic       spriteEval_EN,
  input  logic       spriteEvalReset,
  input  logic       clearOverflow,
  input  logic [8:0] lineCount,
  input  logic       spriteSize16,
  output logic [7:0] oamReadAddr,
  input  logic [7:0] oamReadData,
  output logic [4:0] secOamWriteAddr,
  output logic [7:0] secOamWriteData,
  output logic       secOamWrite_EN,
  output logic [3:0] spriteCount,
  output logic       sprite0InRange,
  output logic       spriteOverflow
);

  // state | meaning
  // IDLE  | armed; first enabled eval tick starts clearing
  // CLEAR | filling secondary OAM with 0xFF on odd dots
  // EVAL  | scanning primary OAM, m selects Y or copied byte
  // FULL  | all slots used; looking for a 9th in-range Y
  // DONE  | scan finished; reads idle at {n,0}
  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] CLEAR = 3'd1;
  localparam logic [2:0] EVAL  = 3'd2;
  localparam logic [2:0] FULL  = 3'd3;
  localparam logic [2:0] DONE  = 3'd4;

  logic [2:0] state;
  logic [8:0] dot;
  logic [5:0] n;
  logic [1:0] m;
  logic [3:0] slot;

  logic [8:0] diff;
  logic       inRange;
  logic       nLast;
  logic [5:0] nNext;

  assign diff    = lineCount - {1'b0, oamReadData};
  assign inRange = diff < (spriteSize16 ? 9'd16 : 9'd8);
  assign nLast   = (n == 6'(OAM_SPRITES - 1));
  assign nNext   = nLast ? 6'd0 : n + 6'd1;

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state           <= IDLE;
      dot             <= 9'd0;
      n               <= 6'd0;
      m               <= 2'd0;
      slot            <= 4'd0;
      oamReadAddr     <= 8'd0;
      secOamWriteAddr <= 5'd0;
      secOamWriteData <= 8'd0;
      secOamWrite_EN  <= 1'b0;
      spriteCount     <= 4'd0;
      sprite0InRange  <= 1'b0;
      spriteOverflow  <= 1'b0;
    end else if (clock_EN) begin
      secOamWrite_EN <= 1'b0;
      if (spriteEvalReset) begin
        state          <= IDLE;
        dot            <= 9'd0;
        n              <= 6'd0;
        m              <= 2'd0;
        slot           <= 4'd0;
        oamReadAddr    <= 8'd0;
        spriteCount    <= 4'd0;
        sprite0InRange <= 1'b0;
      end else if (spriteEval_EN && dot < 9'd256) begin
        dot <= dot + 9'd1;
        case (state)
          IDLE, CLEAR: begin
            state <= (dot == 9'(CLEAR_DOTS - 1)) ? EVAL : CLEAR;
            if (dot[0]) begin
              secOamWriteAddr <= dot[5:1];
              secOamWriteData <= 8'hFF;
              secOamWrite_EN  <= 1'b1;
            end
          end
          EVAL: begin
            if (!dot[0]) begin
              oamReadAddr <= {n, m};
            end else begin
              secOamWriteAddr <= {slot[2:0], m};
              secOamWriteData <= oamReadData;
              secOamWrite_EN  <= 1'b1;
              if (m == 2'd0) begin
                if (inRange) begin
                  m <= 2'd1;
                  if (n == 6'd0) sprite0InRange <= 1'b1;
                end else begin
                  n <= nNext;
                  if (nLast) state <= DONE;
                end
              end else if (m == 2'd3) begin
                m           <= 2'd0;
                slot        <= slot + 4'd1;
                spriteCount <= spriteCount + 4'd1;
                n           <= nNext;
                // A wrap on the last copy ends the line even if slots filled too
                if (nLast) state <= DONE;
                else if (slot == 4'(SEC_SLOTS - 1)) state <= FULL;
              end else begin
                m <= m + 2'd1;
              end
            end
          end
          FULL: begin
            if (!dot[0]) begin
              oamReadAddr <= {n, m};
            end else if (inRange) begin
              spriteOverflow <= 1'b1;
              state          <= DONE;
            end else begin
              n <= nNext;
`ifdef SPRITE_OVERFLOW_BUG_EN
              m <= m + 2'd1;
`else
              m <= 2'd0;
`endif
              if (nLast) state <= DONE;
            end
          end
          DONE: begin
            if (!dot[0]) oamReadAddr <= {n, 2'd0};
          end
          default: state <= IDLE;
        endcase
      end
      if (clearOverflow) spriteOverflow <= 1'b0;
    end
  end

endmodule

// File: tb/tb_sprite_evaluator.sv
// Directed + randomized bench for sprite_evaluator against a scanline-level reference model.
module tb_sprite_evaluator;

  logic       clock = 1'b0;
  logic       reset_n;
  logic       clock_EN;
  logic       spriteEval_EN;
  logic       spriteEvalReset;
  logic       clearOverflow;
  logic [8:0] lineCount;
  logic       spriteSize16;
  logic [7:0] oamReadAddr;
  logic [7:0] oamReadData;
  logic [4:0] secOamWriteAddr;
  logic [7:0] secOamWriteData;
  logic       secOamWrite_EN;
  logic [3:0] spriteCount;
  logic       sprite0InRange;
  logic       spriteOverflow;

  logic [7:0] oam [256];
  logic [7:0] secMem [32];
  int         expSec [32];
  int         expCount;
  bit         expS0;
  bit         expOvf;
  int         writes;
  int         tests = 0;
  int         failures = 0;

  sprite_evaluator dut (
    .clock(clock), .reset_n(reset_n), .clock_EN(clock_EN),
    .spriteEval_EN(spriteEval_EN), .spriteEvalReset(spriteEvalReset),
    .clearOverflow(clearOverflow), .lineCount(lineCount), .spriteSize16(spriteSize16),
    .oamReadAddr(oamReadAddr), .oamReadData(oamReadData),
    .secOamWriteAddr(secOamWriteAddr), .secOamWriteData(secOamWriteData),
    .secOamWrite_EN(secOamWrite_EN), .spriteCount(spriteCount),
    .sprite0InRange(sprite0InRange), .spriteOverflow(spriteOverflow)
  );

  always #5 clock = ~clock;

  assign oamReadData = oam[oamReadAddr];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input logic evalEn, input logic evalRst, input logic clr);
    spriteEval_EN   = evalEn;
    spriteEvalReset = evalRst;
    clearOverflow   = clr;
    @(posedge clock);
    #1;
    if (secOamWrite_EN === 1'b1) begin
      secMem[secOamWriteAddr] = secOamWriteData;
      writes++;
    end
    spriteEval_EN   = 1'b0;
    spriteEvalReset = 1'b0;
    clearOverflow   = 1'b0;
  endtask

  function automatic bit inRange(input int y);
    int d;
    int h;
    d = (int'(lineCount) - y + 512) % 512;
    h = spriteSize16 ? 16 : 8;
    return d < h;
  endfunction

  // Whole-line result from the scan rules; overflow stays sticky across lines.
  task automatic model(input bit clrHeld);
    int slot;
    int y;
    for (int i = 0; i < 32; i++) expSec[i] = 8'hFF;
    expS0 = 0;
    slot  = 0;
    for (int s = 0; s < 64; s++) begin
      y = oam[s*4];
      if (slot < 8) begin
        expSec[slot*4] = y;
        if (inRange(y)) begin
          for (int b = 1; b < 4; b++) expSec[slot*4+b] = oam[s*4+b];
          if (s == 0) expS0 = 1;
          slot++;
        end
      end else if (inRange(y)) begin
        expOvf = 1;
        break;
      end
    end
    expCount = slot;
    if (clrHeld) expOvf = 0;
  endtask

  task automatic dots(input int first, input int last, input bit clr);
    for (int d = first; d <= last; d++) begin
      tick(1'b1, 1'b0, clr);
      if (d < 64) begin
        check("clear_we", secOamWrite_EN, 32'(d % 2));
        if (d % 2 == 1) begin
          check("clear_addr", secOamWriteAddr, 32'(d / 2));
          check("clear_data", secOamWriteData, 32'hFF);
        end
      end
      if (d == 63) begin
        check("clear_writes", writes, 32);
        for (int i = 0; i < 32; i++) check("clear_mem", secMem[i], 32'hFF);
      end
    end
  endtask

  task automatic startLine(input int ln, input bit sz, input bit doReset);
    lineCount    = 9'(ln);
    spriteSize16 = sz;
    if (doReset) begin
      tick(1'b0, 1'b1, 1'b0);
      check("rst_we", secOamWrite_EN, 0);
      check("rst_count", spriteCount, 0);
      check("rst_s0", sprite0InRange, 0);
    end
    writes = 0;
    for (int i = 0; i < 32; i++) secMem[i] = 8'h00;
  endtask

  task automatic endLine(input string tag, input bit clr);
    model(clr);
    check({tag, "_count"}, spriteCount, 32'(expCount));
    check({tag, "_s0"}, sprite0InRange, 32'(expS0));
    check({tag, "_ovf"}, spriteOverflow, 32'(expOvf));
    for (int i = 0; i < 32; i++) check({tag, "_sec"}, secMem[i], 32'(expSec[i]));
    for (int i = 0; i < 4; i++) tick(1'b0, 1'b0, 1'b0);
    check({tag, "_hold_count"}, spriteCount, 32'(expCount));
    check({tag, "_hold_ovf"}, spriteOverflow, 32'(expOvf));
  endtask

  task automatic runLine(input string tag, input int ln, input bit sz, input bit doReset, input bit clr);
    startLine(ln, sz, doReset);
    dots(0, 255, clr);
    endLine(tag, clr);
  endtask

  task automatic fillOam(input logic [7:0] y);
    for (int i = 0; i < 256; i++) oam[i] = (i % 4 == 0) ? y : 8'(i);
  endtask

  initial begin
    logic [3:0] savedCount;
    int ln;
    reset_n = 1'b0; clock_EN = 1'b1; spriteEval_EN = 1'b0; spriteEvalReset = 1'b0;
    clearOverflow = 1'b0; lineCount = 9'd0; spriteSize16 = 1'b0;
    expOvf = 0;
    fillOam(8'hF0);

    for (int i = 0; i < 3; i++) tick(1'b0, 1'b0, 1'b0);
    check("reset_oamAddr", oamReadAddr, 0);
    check("reset_secAddr", secOamWriteAddr, 0);
    check("reset_secData", secOamWriteData, 0);
    check("reset_we", secOamWrite_EN, 0);
    check("reset_count", spriteCount, 0);
    check("reset_s0", sprite0InRange, 0);
    check("reset_ovf", spriteOverflow, 0);
    reset_n = 1'b1;

    // Line 10 straight out of reset, nothing in range
    runLine("line10", 10, 1'b0, 1'b0, 1'b0);

    // Sprite 0 in range on line 20
    oam[0] = 8'd15; oam[1] = 8'h42; oam[2] = 8'h01; oam[3] = 8'h80;
    runLine("sprite0", 20, 1'b0, 1'b1, 1'b0);
    check("sprite0_b0", secMem[0], 15);
    check("sprite0_b1", secMem[1], 32'h42);
    check("sprite0_b3", secMem[3], 32'h80);
    check("sprite0_cnt", spriteCount, 1);
    check("sprite0_flag", sprite0InRange, 1);

    // Diff of exactly 8: out for 8x8, in for 8x16
    fillOam(8'hF0);
    oam[12] = 8'd12; oam[13] = 8'h33; oam[14] = 8'h44; oam[15] = 8'h55;
    runLine("edge8", 20, 1'b0, 1'b1, 1'b0);
    check("edge8_cnt", spriteCount, 0);
    runLine("edge16", 20, 1'b1, 1'b1, 1'b0);
    check("edge16_cnt", spriteCount, 1);
    check("edge16_b1", secMem[1], 32'h33);
    check("edge16_s0", sprite0InRange, 0);

    // Nine sprites on one line -> overflow, then clearOverflow
    fillOam(8'hF0);
    for (int s = 0; s < 9; s++) oam[s*4] = 8'd20;
    runLine("nine", 22, 1'b0, 1'b1, 1'b0);
    check("nine_cnt", spriteCount, 8);
    check("nine_ovf", spriteOverflow, 1);
    tick(1'b0, 1'b0, 1'b1);
    expOvf = 0;
    check("clrovf", spriteOverflow, 0);

    // Clear held through an overflowing line: clear wins
    runLine("clrwins", 22, 1'b0, 1'b1, 1'b1);
    check("clrwins_ovf", spriteOverflow, 0);

    // Exactly eight sprites: no overflow
    fillOam(8'hF0);
    for (int s = 0; s < 8; s++) oam[(s*7)*4] = 8'd20;
    runLine("eight", 22, 1'b0, 1'b1, 1'b0);
    check("eight_ovf", spriteOverflow, 0);

    // clock_EN low: nothing moves
    savedCount = spriteCount;
    clock_EN = 1'b0;
    tick(1'b1, 1'b1, 1'b0);
    tick(1'b1, 1'b0, 1'b0);
    check("gated_count", spriteCount, 32'(savedCount));
    check("gated_we", secOamWrite_EN, 0);
    clock_EN = 1'b1;

    // Reset mid-copy of sprite 38 at dot 150
    fillOam(8'hF0);
    oam[0] = 8'd20; oam[38*4] = 8'd20;
    startLine(22, 1'b0, 1'b1);
    dots(0, 149, 1'b0);
    check("mid_cnt_before", spriteCount, 1);
    tick(1'b0, 1'b1, 1'b0);
    check("mid_cnt", spriteCount, 0);
    check("mid_s0", sprite0InRange, 0);
    check("mid_we", secOamWrite_EN, 0);
    writes = 0;
    for (int i = 0; i < 32; i++) secMem[i] = 8'h00;
    dots(0, 255, 1'b0);
    endLine("mid", 1'b0);

    // Randomized lines with Y values clustered near the scanline
    for (int t = 0; t < 10; t++) begin
      ln = $urandom_range(0, 239);
      for (int i = 0; i < 256; i++) oam[i] = 8'($urandom);
      for (int s = 0; s < 64; s++)
        if ($urandom_range(0, 3) == 0) oam[s*4] = 8'(ln - $urandom_range(0, 17));
      runLine("rand", ln, 1'($urandom_range(0, 1)), 1'b1, 1'b0);
      if ($urandom_range(0, 2) == 0) begin
        tick(1'b0, 1'b0, 1'b1);
        expOvf = 0;
        check("rand_clrovf", spriteOverflow, 0);
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule
